// File: rtl/prmcu_uart_pkg.sv
// Shared UART types and constants for the prmcu transmit and receive paths.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package prmcu_uart_pkg;

  localparam int UART_MIN_DATA_BITS = 5;
  localparam int UART_MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Frame configuration, latched once per frame so that mid-frame changes
  // on the configuration inputs cannot corrupt a frame in flight.
  typedef struct packed {
    logic       parity_en;
    logic [1:0] n_stop;
    logic [3:0] n_data;
  } uart_cfg_t;

  // Folds raw configuration inputs into legal values: stop 0 -> 1, 3 -> 2;
  // data bits clamped to 5..9.
  function automatic uart_cfg_t uart_cfg_norm(input logic       parity,
                                              input logic [1:0] stop,
                                              input logic [3:0] data);
    uart_cfg_t c;
    c.parity_en = parity;
    if (stop == 2'd0)      c.n_stop = 2'd1;
    else if (stop == 2'd3) c.n_stop = 2'd2;
    else                   c.n_stop = stop;
    if (data < 4'(UART_MIN_DATA_BITS))      c.n_data = 4'(UART_MIN_DATA_BITS);
    else if (data > 4'(UART_MAX_DATA_BITS)) c.n_data = 4'(UART_MAX_DATA_BITS);
    else                                    c.n_data = data;
    return c;
  endfunction

endpackage

// File: rtl/prmcu_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
// Latency: 2 clk cycles. Backpressure: none (free-running).
// Ports: clk, rst (async active-high), i_d (async input), o_q (synchronized).
module prmcu_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ff <= {2{RST_VAL}};
    else     r_ff <= {r_ff[0], i_d};
  end

  assign o_q = r_ff[1];

endmodule

// File: rtl/prmcu_uart_receiver.sv
// UART receive stage: deframes start/data/parity/stop from rx_i into a one-entry buffer.
// Latency: out_vld_o rises 1 clk after the final stop-bit sample (sync adds 2 clk on the input).
// Backpressure: one-entry valid/ready buffer; a frame completing while it is full is dropped and overrun_o pulses.
// Ports: clk/rst; uart_en, rx_en enables; n_parity_bits_i, n_stop_bits_i, n_data_bits_i,
//        internal_clk_divider_i frame config; rx_i serial in; out_dat_o/out_vld_o/out_rdy_i
//        output handshake; parity_err_o, frame_err_o per-frame flags; overrun_o drop pulse.
module prmcu_uart_receiver
  import prmcu_uart_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_en,
  input  logic             rx_en,
  input  logic             n_parity_bits_i,
  input  logic [1:0]       n_stop_bits_i,
  input  logic [3:0]       n_data_bits_i,
  input  logic [DIV_W-1:0] internal_clk_divider_i,
  input  logic             rx_i,
  output logic [8:0]       out_dat_o,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             overrun_o
);

  logic             w_rx_s;
  logic             r_rx_prev;
  rx_state_t        r_state, w_state_nxt;
  uart_cfg_t        r_cfg;
  logic [DIV_W-1:0] r_cnt;
  logic [3:0]       r_bit_idx;
  logic [8:0]       r_shift;
  logic             r_par_acc, r_perr, r_ferr;
  logic [8:0]       r_out_dat;
  logic             r_out_vld, r_out_perr, r_out_ferr, r_ovr;

  logic w_en, w_fall, w_sample, w_last_data, w_last_stop, w_commit;

  prmcu_sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx_i),
    .o_q (w_rx_s)
  );

  assign w_en        = uart_en & rx_en;
  assign w_fall      = w_en & r_rx_prev & ~w_rx_s;
  assign w_sample    = (r_state != RX_IDLE) && (r_cnt == '0);
  assign w_last_data = (r_bit_idx == r_cfg.n_data - 4'd1);
  assign w_last_stop = (r_bit_idx == {2'b00, r_cfg.n_stop} - 4'd1);
  assign w_commit    = w_en && (r_state == RX_STOP) && w_sample && w_last_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RX_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_en) begin
      w_state_nxt = RX_IDLE;
    end else begin
      case (r_state)
        RX_IDLE:   if (w_fall) w_state_nxt = RX_START;
        // A high line at mid start bit means the edge was a glitch.
        RX_START:  if (w_sample) w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
        RX_DATA:   if (w_sample && w_last_data)
                     w_state_nxt = r_cfg.parity_en ? RX_PARITY : RX_STOP;
        RX_PARITY: if (w_sample) w_state_nxt = RX_STOP;
        RX_STOP:   if (w_sample && w_last_stop) w_state_nxt = RX_IDLE;
        default:   w_state_nxt = RX_IDLE;
      endcase
    end
  end

  // Bit timing and deframing datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_prev <= 1'b1;
      r_cfg     <= '0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_acc <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_prev <= w_rx_s;
      if (r_state == RX_IDLE) begin
        if (w_fall) begin
          r_cnt     <= internal_clk_divider_i >> 1;
          r_cfg     <= uart_cfg_norm(n_parity_bits_i, n_stop_bits_i, n_data_bits_i);
          r_bit_idx <= '0;
          r_shift   <= '0;
          r_par_acc <= 1'b0;
          r_perr    <= 1'b0;
          r_ferr    <= 1'b0;
        end
      end else if (w_sample) begin
        r_cnt <= internal_clk_divider_i - 1'b1;
        case (r_state)
          RX_DATA: begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_par_acc          <= r_par_acc ^ w_rx_s;
            r_bit_idx          <= w_last_data ? 4'd0 : r_bit_idx + 4'd1;
          end
          RX_PARITY: r_perr <= (w_rx_s != r_par_acc);
          RX_STOP: begin
            r_ferr    <= r_ferr | ~w_rx_s;
            r_bit_idx <= r_bit_idx + 4'd1;
          end
          default: r_bit_idx <= '0;
        endcase
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // One-entry output buffer. The final stop sample is folded in directly
  // because its pending flag would only land one cycle after the commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_dat  <= '0;
      r_out_vld  <= 1'b0;
      r_out_perr <= 1'b0;
      r_out_ferr <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_commit && (!r_out_vld || out_rdy_i)) begin
        r_out_dat  <= r_shift;
        r_out_perr <= r_perr;
        r_out_ferr <= r_ferr | ~w_rx_s;
        r_out_vld  <= 1'b1;
      end else begin
        if (w_commit)               r_ovr     <= 1'b1;
        if (r_out_vld && out_rdy_i) r_out_vld <= 1'b0;
      end
    end
  end

  assign out_dat_o    = r_out_dat;
  assign out_vld_o    = r_out_vld;
  assign parity_err_o = r_out_perr;
  assign frame_err_o  = r_out_ferr;
  assign overrun_o    = r_ovr;

endmodule
